// File: rtl/mips_cpu_mem_unit.sv
// mips_cpu_mem_unit: MIPS load/store unit bridging core requests to an Avalon-MM master port.
//
// Ports:
//   clk, reset            sole clock, synchronous active-high reset
//   req_valid/req_ready   core request handshake (accepted only while idle)
//   req_op                LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW encoding, others illegal
//   req_addr              byte address
//   req_wdata, req_rt     store source and current rt (LWL/LWR merge)
//   resp_valid            one-cycle completion pulse with resp_rdata and resp_err
//   address               word-aligned Avalon address
//   read, write           Avalon requests, held until waitrequest drops
//   waitrequest           Avalon stall
//   writedata, byteenable Avalon write data and byte-lane mask
//   readdata              Avalon read data, valid the cycle after the read is accepted
module mips_cpu_mem_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, RESP} state_t;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rt_q, rt_d;
    logic [31:0]         tcnt_q, tcnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                legal, misal;
    logic [1:0]          k;
    logic [31:0]         lane, load_val, st_wd;
    logic [3:0]          st_be;

    assign k = addr_q[1:0];

    // Request screening is done on the live inputs so a bad request goes straight to RESP.
    assign legal = (req_op <= OP_LWR) || (req_op >= OP_SB && req_op <= OP_SW);
    assign misal = ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0]) ||
                   ((req_op == OP_LW || req_op == OP_SW) && req_addr[1:0] != 2'b00);

    // Little-endian lane extraction and LWL/LWR merge with the old rt value.
    assign lane = readdata >> {k, 3'b000};

    always_comb begin
        load_val = readdata;
        case (op_q)
            OP_LB:   load_val = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  load_val = {24'h0, lane[7:0]};
            OP_LH:   load_val = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  load_val = {16'h0, lane[15:0]};
            OP_LWL:  load_val = (readdata << {~k, 3'b000}) | (rt_q & ~(32'hFFFF_FFFF << {~k, 3'b000}));
            OP_LWR:  load_val = lane | (rt_q & ~(32'hFFFF_FFFF >> {k, 3'b000}));
            default: load_val = readdata;
        endcase
    end

    // Sub-word stores replicate the data across lanes and let byteenable pick the target.
    always_comb begin
        st_wd = wdata_q;
        st_be = 4'b1111;
        case (op_q)
            OP_SB: begin
                st_wd = {4{wdata_q[7:0]}};
                st_be = 4'b0001 << k;
            end
            OP_SH: begin
                st_wd = {2{wdata_q[15:0]}};
                st_be = k[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wd = wdata_q;
                st_be = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rt_d    = rt_q;
        tcnt_d  = tcnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rt_d    = req_rt;
                    tcnt_d  = 32'd0;
                    rdata_d = 32'd0;
                    err_d   = !legal || misal;
                    state_d = (!legal || misal) ? RESP : (req_op[3] ? WR_REQ : RD_REQ);
                end
            end
            RD_REQ, WR_REQ: begin
                if (!waitrequest) begin
                    state_d = (state_q == RD_REQ) ? RD_DATA : RESP;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                    // Abort on the edge the count reaches the limit so the request drops next cycle.
                    if (TIMEOUT != 0 && tcnt_d == 32'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RD_DATA: begin
                rdata_d = load_val;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rt_q    <= 32'd0;
            tcnt_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rt_q    <= rt_d;
            tcnt_q  <= tcnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign read       = (state_q == RD_REQ);
    assign write      = (state_q == WR_REQ);
    assign address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign writedata  = write ? st_wd : 32'd0;
    assign byteenable = read ? 4'b1111 : (write ? st_be : 4'b0000);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_err   = resp_valid && err_q;
endmodule

// File: tb/tb_mips_cpu_mem_unit.sv
// tb_mips_cpu_mem_unit: randomized self-checking bench with a byte-level memory reference model.
module tb_mips_cpu_mem_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_rt;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, address;
    logic        read, write, waitrequest;
    logic [31:0] writedata, readdata;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_mem_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] seed(input int i);
        logic [31:0] x;
        x = 32'(i);
        return (x * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // Two 256-byte windows at 0x1000 and 0x2000.
    function automatic int widx(input logic [31:0] a);
        return int'({a[13], a[7:2]});
    endfunction

    function automatic int bidx(input logic [31:0] a);
        return int'({a[13], a[7:0]});
    endfunction

    // Avalon slave memory and bus monitor (owned by the responder process).
    logic [31:0] mw [128];
    int          wait_total = 0, bus_total = 0, resp_total = 0;
    int          both_cnt = 0, idle_bad = 0, unstable = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] f_addr, f_wd;
    logic [3:0]  f_be;

    // Stimulus-side controls and reference model.
    logic        stk = 1'b0, mem_init = 1'b1;
    int          w_base = 0, nw_cur = 0, exp_resp = 0;
    logic [7:0]  rb [512];

    always @(posedge clk) begin
        if (mem_init)
            for (int i = 0; i < 128; i++) mw[i] <= seed(i);
        if (read || write) begin
            bus_total <= bus_total + 1;
            if (waitrequest) wait_total <= wait_total + 1;
            if (!prev_busy) begin
                f_addr <= address;
                f_wd   <= writedata;
                f_be   <= byteenable;
            end else if (address !== f_addr || writedata !== f_wd || byteenable !== f_be) begin
                unstable <= unstable + 1;
            end
        end else if (byteenable != 4'd0 || writedata != 32'd0) begin
            idle_bad <= idle_bad + 1;
        end
        if (read && write) both_cnt <= both_cnt + 1;
        if (resp_valid) resp_total <= resp_total + 1;
        prev_busy <= read || write;
        if (write && !waitrequest)
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mw[widx(address)][8*b +: 8] <= writedata[8*b +: 8];
        readdata <= (read && !waitrequest) ? mw[widx(address)] : $urandom;
    end

    always @(negedge clk)
        waitrequest <= (read || write) ? (stk || (wait_total - w_base) < nw_cur) : 1'($urandom);

    task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rt, input int nw, input logic st);
        logic        bad, is_st, got_err;
        logic [31:0] exp_rd, w, got_rd, exp_wd;
        logic [7:0]  bt;
        logic [15:0] h;
        logic [3:0]  exp_be;
        int          k, sh, exp_lat, exp_bus, lat, b0, bi, wb;
        k      = int'(a[1:0]);
        bi     = bidx(a);
        wb     = bidx({a[31:2], 2'b00});
        bad    = !(op <= 4'd6 || (op >= 4'd8 && op <= 4'd10)) ||
                 ((op == 4'd2 || op == 4'd3 || op == 4'd9) && a[0]) ||
                 ((op == 4'd4 || op == 4'd10) && a[1:0] != 2'b00);
        is_st  = op[3];
        w      = {rb[wb+3], rb[wb+2], rb[wb+1], rb[wb]};
        bt     = rb[bi];
        h      = {rb[(bi+1) % 512], rb[bi]};
        exp_rd = 32'd0;
        if (!bad && !st && !is_st) begin
            case (op)
                4'd0: exp_rd = bt[7] ? (32'hFFFF_FF00 | 32'(bt)) : 32'(bt);
                4'd1: exp_rd = 32'(bt);
                4'd2: exp_rd = h[15] ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
                4'd3: exp_rd = 32'(h);
                4'd4: exp_rd = w;
                4'd5: begin
                    sh = 8 * (3 - k);
                    exp_rd = (w << sh) | (rt & 32'((64'd1 << sh) - 64'd1));
                end
                default: begin
                    sh = 8 * k;
                    exp_rd = (w >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
                end
            endcase
        end
        exp_wd  = (op == 4'd8) ? {4{wd[7:0]}} : (op == 4'd9) ? {2{wd[15:0]}} : wd;
        exp_be  = (op == 4'd8) ? (4'b0001 << k) : (op == 4'd9) ? ((k == 0) ? 4'b0011 : 4'b1100) : 4'b1111;
        exp_lat = bad ? 1 : st ? TO + 1 : is_st ? 2 + nw : 3 + nw;
        exp_bus = bad ? 0 : st ? TO : 1 + nw;
        stk = st;
        nw_cur = nw;
        w_base = wait_total;
        b0 = bus_total;
        check("ready", req_ready, 1);
        req_valid = 1'b1;
        req_op = op;
        req_addr = a;
        req_wdata = wd;
        req_rt = rt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 4'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        req_rt = $urandom;
        lat = 0;
        got_rd = 32'd0;
        got_err = 1'b0;
        for (int j = 1; j <= 20 && lat == 0; j++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = j;
                got_rd = resp_rdata;
                got_err = resp_err;
            end
        end
        check("latency", lat, exp_lat);
        check("rdata", got_rd, exp_rd);
        check("err", got_err, bad || st);
        check("bus_cycles", bus_total - b0, exp_bus);
        if (!bad) begin
            check("addr", f_addr, {a[31:2], 2'b00});
            check("be", f_be, is_st ? exp_be : 4'b1111);
            if (is_st) check("wdata", f_wd, exp_wd);
        end
        exp_resp++;
        @(negedge clk);
        check("pulse_end", {resp_valid, req_ready}, 2'b01);
        stk = 1'b0;
        if (is_st && !bad && !st) begin
            if (op == 4'd8) rb[bi] = wd[7:0];
            else if (op == 4'd9) begin
                rb[bi] = wd[7:0];
                rb[bi+1] = wd[15:8];
            end else
                for (int i = 0; i < 4; i++) rb[bi+i] = wd[8*i +: 8];
        end
    endtask

    task automatic rand_req();
        logic [31:0] a;
        a = ($urandom_range(0, 1) ? 32'h1000 : 32'h2000) | 32'($urandom_range(0, 255));
        do_req(4'($urandom_range(0, 15)), a, $urandom, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 15) == 0);
    endtask

    initial begin
        int r0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 4'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_rt = 32'd0;
        for (int i = 0; i < 512; i++) rb[i] = 8'(seed(i >> 2) >> (8 * (i % 4)));
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        check("rst_ctrl", {req_ready, read, write, resp_valid, resp_err, byteenable}, 9'b1_0000_0000);
        check("rst_wdata", writedata, 0);
        check("rst_rdata", resp_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        do_req(4'd10, 32'h1000, 32'h8899_AABB, 32'd0, 0, 1'b0);
        do_req(4'd4,  32'h1000, 32'd0, 32'd0, 0, 1'b0);
        do_req(4'd0,  32'h1003, 32'd0, 32'd0, 0, 1'b0);
        do_req(4'd1,  32'h1003, 32'd0, 32'd0, 1, 1'b0);
        do_req(4'd3,  32'h1002, 32'd0, 32'd0, 2, 1'b0);
        do_req(4'd9,  32'h2002, 32'h1234_ABCD, 32'd0, 3, 1'b0);
        do_req(4'd4,  32'h2000, 32'd0, 32'd0, 0, 1'b0);
        do_req(4'd10, 32'h1000, 32'hAABB_CCDD, 32'd0, 0, 1'b0);
        do_req(4'd5,  32'h1001, 32'd0, 32'h1122_3344, 0, 1'b0);
        do_req(4'd6,  32'h1001, 32'd0, 32'h1122_3344, 0, 1'b0);
        do_req(4'd10, 32'h2001, 32'h5555_5555, 32'd0, 0, 1'b0);
        do_req(4'd2,  32'h1005, 32'd0, 32'd0, 0, 1'b0);
        do_req(4'd7,  32'h1000, 32'd0, 32'd0, 0, 1'b0);
        do_req(4'd15, 32'h1000, 32'd0, 32'd0, 0, 1'b0);
        do_req(4'd4,  32'h1000, 32'd0, 32'd0, 0, 1'b1);
        do_req(4'd10, 32'h2004, 32'hDEAD_BEEF, 32'd0, 0, 1'b1);
        do_req(4'd4,  32'h2004, 32'd0, 32'd0, 3, 1'b0);
        do_req(4'd8,  32'h2007, 32'h0000_00A5, 32'd0, 1, 1'b0);
        do_req(4'd6,  32'h2007, 32'd0, 32'hCAFE_F00D, 0, 1'b0);
        do_req(4'd5,  32'h2004, 32'd0, 32'hCAFE_F00D, 0, 1'b0);

        repeat (200) rand_req();

        // Reset while a read is stalled must abandon it silently.
        stk = 1'b1;
        nw_cur = 0;
        w_base = wait_total;
        req_valid = 1'b1;
        req_op = 4'd4;
        req_addr = 32'h1000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_read", read, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid", {read, write, resp_valid, req_ready, byteenable}, 8'b0001_0000);
        stk = 1'b0;
        r0 = resp_total;
        repeat (5) @(negedge clk);
        check("rst_no_resp", resp_total - r0, 0);

        repeat (60) rand_req();

        check("rw_exclusive", both_cnt, 0);
        check("idle_bus_zero", idle_bad, 0);
        check("bus_stable", unstable, 0);
        check("resp_count", resp_total, exp_resp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_cpu_mem_unit.md
MIPS_CPU_MEM_UNIT -- requirements
Module: mips_cpu_mem_unit

Interface
REQ-001 Parameter ADDR_W, default 32, gives the byte-address width of the request and bus address ports.
REQ-002 Parameter TIMEOUT, default 0, sets the abort limit in waitrequest cycles; 0 disables the abort.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  core requests a load/store; sampled only while req_ready=1.
REQ-006 req_ready  out  1  unit is idle and accepts a request this cycle.
REQ-007 req_op  in  4  access type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; any other value is illegal.
REQ-008 req_addr  in  ADDR_W  byte address (rs + sign-extended immediate).
REQ-009 req_wdata  in  32  store source (rt).
REQ-010 req_rt  in  32  current rt value, used for LWL/LWR merge.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-013 resp_err  out  1  misaligned, illegal op or timeout; valid with resp_valid.
REQ-014 address  out  ADDR_W  Avalon word address, always {req_addr[ADDR_W-1:2],2'b00}.
REQ-015 read / write  out  1 each  Avalon read and write requests.
REQ-016 waitrequest  in  1  Avalon stall; the current read/write is not accepted while high.
REQ-017 writedata  out  32 and byteenable  out  4  Avalon write data and byte-lane mask.
REQ-018 readdata  in  32  Avalon read data, valid the cycle after read=1 is accepted with waitrequest=0.

Function
REQ-019 The unit SHALL implement the FSM states IDLE, RD_REQ, RD_DATA, WR_REQ and RESP.
REQ-020 IDLE: req_ready=1; req_valid=1 latches op, addr, wdata and rt, then goes to RD_REQ (loads), WR_REQ (stores) or RESP with error (misaligned/illegal).
REQ-021 Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; LB/LBU/SB/LWL/LWR are never misaligned.
REQ-022 RD_REQ drives read=1 with address and byteenable held stable; on waitrequest=0 it goes to RD_DATA.
REQ-023 WR_REQ drives write=1 with address, writedata and byteenable held stable; on waitrequest=0 it goes to RESP.
REQ-024 RD_DATA captures readdata, formats it per REQ-027..029, then goes to RESP.
REQ-025 RESP asserts resp_valid for exactly one cycle and returns to IDLE; req_ready=0 in every state except IDLE.
REQ-026 Latency from the accept edge with zero wait states: error responses pulse at cycle N+1, stores at N+2, loads at N+3; each waitrequest cycle adds one cycle.
REQ-027 Lanes are little-endian with k=addr[1:0]: LB/LBU select byte k; LH/LHU select bytes k+1..k; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-028 LWL SHALL return (mem << 8*(3-k)) | (rt & (2^(8*(3-k))-1)).
REQ-029 LWR SHALL return (mem >> 8*k) | (rt & ~(32'hFFFFFFFF >> 8*k)).
REQ-030 Load byteenable SHALL be 4'b1111 for all load ops.
REQ-031 SB drives writedata = the byte replicated into all 4 lanes, byteenable = 1<<k.
REQ-032 SH drives writedata = the half replicated into both halves, byteenable = 0011 (k=0) or 1100 (k=2).
REQ-033 SW drives writedata = wdata, byteenable = 1111.
REQ-034 read and write SHALL never be asserted in the same cycle.
REQ-035 Outside RD_REQ/WR_REQ: read=write=0, writedata=0, byteenable=0.
REQ-036 Timeout: a counter increments on each waitrequest=1 cycle in RD_REQ or WR_REQ.
REQ-037 When TIMEOUT>0 and the counter reaches TIMEOUT, the unit drops read/write the next cycle and enters RESP with resp_err=1 and resp_rdata=0.
REQ-038 The timeout counter clears on every accept.
REQ-039 req_valid while busy is ignored; the core holds the request until req_ready.

Reset
REQ-040 Reset=1 SHALL force state IDLE and, from the next cycle, read=write=0, resp_valid=0, resp_err=0, resp_rdata=0, byteenable=0, writedata=0, req_ready=1 and timeout count 0.
REQ-041 Reset mid-transaction SHALL abandon the transaction with no resp_valid pulse.

Verification
REQ-042 LW addr 0x1000, readdata 0x8899AABB, no waits -> read at N+1, address 0x1000, resp_valid at N+3, rdata 0x8899AABB, err 0.
REQ-043 LB addr 0x1003, readdata 0x8899AABB -> rdata 0xFFFFFF88; LBU same -> 0x00000088; LHU addr 0x1002 -> 0x00008899.
REQ-044 SH addr 0x2002, wdata 0x1234ABCD, 3 waitrequest cycles -> write held 4 cycles, writedata 0xABCDABCD, byteenable 1100, resp_valid at N+5.
REQ-045 LWL addr 0x1001, rt 0x11223344, mem 0xAABBCCDD -> 0xCCDD3344; LWR addr 0x1001, same inputs -> 0x11AABBCC.
REQ-046 SW addr 0x2001 -> no bus cycle, resp_valid at N+1, err 1; TIMEOUT=4 with waitrequest stuck high -> read drops after 4 wait cycles, resp_err=1.
REQ-047 Reset asserted during an RD_REQ wait -> read=0 the next cycle, no resp_valid, req_ready=1.
